// File: rtl/ppi_pkg.sv
// Shared constants for the parallel port bank: register map and default data width.
package ppi_pkg;

    localparam int PPI_DATA_W_DEF = 8;
    localparam int PPI_MAX_PORTS  = 4;

    localparam logic [3:0] ADDR_DATA0  = 4'd0;
    localparam logic [3:0] ADDR_DDR0   = 4'd4;
    localparam logic [3:0] ADDR_MODE   = 4'd8;
    localparam logic [3:0] ADDR_STATUS = 4'd9;

endpackage

// File: rtl/ppi_sync.sv
// Two-flop synchronizer for asynchronous pins, with a rising-edge pulse taken
// from the synchronized level.
module ppi_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         Rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic [W-1:0] rise
);

    logic [W-1:0] meta;
    logic [W-1:0] q_d;

    always_ff @(posedge clk) begin
        if (Rst) begin
            meta <= '0;
            q    <= '0;
            q_d  <= '0;
        end else begin
            meta <= d;
            q    <= meta;
            q_d  <= q;
        end
    end

    assign rise = q & ~q_d;

endmodule

// File: rtl/ppi_port_bank.sv
// Programmable parallel port bank: per-port output latch, direction register and
// optional strobed input latch. Define PPI_IRQ_EN to add the Irq output (IE = MODE[7:4]).
module ppi_port_bank
    import ppi_pkg::*;
#(
    parameter int DATA_W    = PPI_DATA_W_DEF,
    parameter int NUM_PORTS = 3
) (
    input  logic                          clk,
    input  logic                          Rst,
    input  logic [3:0]                    Addr,
    input  logic                          Wr,
    input  logic                          Rd,
    input  logic [DATA_W-1:0]             D_In,
    output logic [DATA_W-1:0]             D_Out,
    output logic                          Rd_Valid,
    input  logic [NUM_PORTS*DATA_W-1:0]   Port_In,
    output logic [NUM_PORTS*DATA_W-1:0]   Port_Out,
    output logic [NUM_PORTS*DATA_W-1:0]   Port_Oe,
    input  logic [NUM_PORTS-1:0]          Stb,
    output logic [NUM_PORTS-1:0]          Ibf
`ifdef PPI_IRQ_EN
    ,
    output logic                          Irq
`endif
);

    logic [DATA_W-1:0]           out_latch [NUM_PORTS];
    logic [DATA_W-1:0]           ddr       [NUM_PORTS];
    logic [DATA_W-1:0]           in_latch  [NUM_PORTS];
    logic [3:0]                  mode_sel;
    logic [NUM_PORTS-1:0]        ibf;
    logic [NUM_PORTS-1:0]        ovr;
    logic [NUM_PORTS*DATA_W-1:0] pin_sync;
    logic [NUM_PORTS*DATA_W-1:0] pin_rise_unused;
    logic [NUM_PORTS-1:0]        stb_level_unused;
    logic [NUM_PORTS-1:0]        stb_rise;
    logic [NUM_PORTS-1:0]        rd_clr;
    logic [7:0]                  mode_rd;
    logic [7:0]                  status_rd;
    logic [DATA_W-1:0]           rd_data;
    logic                        wr_mode;
    logic                        rd_status;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        ppi_sync #(.W(DATA_W)) u_pin_sync (
            .clk  (clk),
            .Rst  (Rst),
            .d    (Port_In[g*DATA_W +: DATA_W]),
            .q    (pin_sync[g*DATA_W +: DATA_W]),
            .rise (pin_rise_unused[g*DATA_W +: DATA_W])
        );
        ppi_sync #(.W(1)) u_stb_sync (
            .clk  (clk),
            .Rst  (Rst),
            .d    (Stb[g]),
            .q    (stb_level_unused[g]),
            .rise (stb_rise[g])
        );
        assign Port_Out[g*DATA_W +: DATA_W] = out_latch[g];
        assign Port_Oe[g*DATA_W +: DATA_W]  = ddr[g];
    end

    assign wr_mode   = Wr && (Addr == ADDR_MODE);
    assign rd_status = Rd && (Addr == ADDR_STATUS);
    assign status_rd = {4'(ovr), 4'(ibf)};
    assign Ibf       = ibf;

`ifdef PPI_IRQ_EN
    logic [3:0] ie;
    assign mode_rd = {ie, mode_sel};

    always_ff @(posedge clk) begin
        if (Rst) begin
            ie  <= '0;
            Irq <= 1'b0;
        end else begin
            if (wr_mode) ie <= D_In[7:4];
            Irq <= |(4'(ibf) & ie);
        end
    end
`else
    assign mode_rd = {4'b0000, mode_sel};
`endif

    // Read mux sees only registered state, so a same-cycle write is not visible.
    always_comb begin
        rd_data = '0;
        rd_clr  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (Addr == ADDR_DATA0 + 4'(i)) begin
                rd_data   = (ddr[i] & out_latch[i]) |
                            (~ddr[i] & (mode_sel[i] ? in_latch[i]
                                                    : pin_sync[i*DATA_W +: DATA_W]));
                rd_clr[i] = Rd && mode_sel[i];
            end
            if (Addr == ADDR_DDR0 + 4'(i)) rd_data = ddr[i];
        end
        if (Addr == ADDR_MODE)   rd_data = DATA_W'(mode_rd);
        if (Addr == ADDR_STATUS) rd_data = DATA_W'(status_rd);
    end

    // Handshake: Rd is a one-cycle request; exactly one cycle later Rd_Valid pulses
    // for one cycle with D_Out holding the data. D_Out is zero when Rd_Valid is low.
    always_ff @(posedge clk) begin
        if (Rst) begin
            D_Out    <= '0;
            Rd_Valid <= 1'b0;
        end else begin
            Rd_Valid <= Rd;
            D_Out    <= Rd ? rd_data : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            mode_sel <= '0;
            ibf      <= '0;
            ovr      <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                out_latch[i] <= '0;
                ddr[i]       <= '0;
                in_latch[i]  <= '0;
            end
        end else begin
            if (wr_mode) mode_sel <= D_In[3:0];
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (Wr && (Addr == ADDR_DATA0 + 4'(i))) out_latch[i] <= D_In;
                if (Wr && (Addr == ADDR_DDR0 + 4'(i)))  ddr[i]       <= D_In;
                if (wr_mode && !D_In[i]) begin
                    ibf[i] <= 1'b0;
                    ovr[i] <= 1'b0;
                end else if (mode_sel[i]) begin
                    // A new overrun in the same cycle as a STATUS read wins over the clear.
                    if (rd_status) ovr[i] <= 1'b0;
                    if (stb_rise[i]) begin
                        if (ibf[i] && !rd_clr[i]) begin
                            ovr[i] <= 1'b1;
                        end else begin
                            in_latch[i] <= pin_sync[i*DATA_W +: DATA_W];
                            ibf[i]      <= 1'b1;
                        end
                    end else if (rd_clr[i]) begin
                        ibf[i] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ppi_port_bank.sv
// Directed bench for ppi_port_bank: reads push expected data into a queue and a
// negedge monitor pops and compares on every Rd_Valid.
module tb_ppi_port_bank;

  localparam int DATA_W    = 8;
  localparam int NUM_PORTS = 3;

  logic                        clk = 1'b0;
  logic                        Rst;
  logic [3:0]                  Addr;
  logic                        Wr;
  logic                        Rd;
  logic [DATA_W-1:0]           D_In;
  logic [DATA_W-1:0]           D_Out;
  logic                        Rd_Valid;
  logic [NUM_PORTS*DATA_W-1:0] Port_In;
  logic [NUM_PORTS*DATA_W-1:0] Port_Out;
  logic [NUM_PORTS*DATA_W-1:0] Port_Oe;
  logic [NUM_PORTS-1:0]        Stb;
  logic [NUM_PORTS-1:0]        Ibf;
`ifdef PPI_IRQ_EN
  logic                        Irq;
`endif

  logic [DATA_W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  ppi_port_bank #(.DATA_W(DATA_W), .NUM_PORTS(NUM_PORTS)) dut (
    .clk      (clk),
    .Rst      (Rst),
    .Addr     (Addr),
    .Wr       (Wr),
    .Rd       (Rd),
    .D_In     (D_In),
    .D_Out    (D_Out),
    .Rd_Valid (Rd_Valid),
    .Port_In  (Port_In),
    .Port_Out (Port_Out),
    .Port_Oe  (Port_Oe),
    .Stb      (Stb),
    .Ibf      (Ibf)
`ifdef PPI_IRQ_EN
    ,
    .Irq      (Irq)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [3:0] a, input logic [7:0] d);
    Addr = a; D_In = d; Wr = 1'b1;
    tick();
    Wr = 1'b0;
  endtask

  task automatic cpu_read(input logic [3:0] a, input logic [7:0] exp);
    exp_q.push_back(exp);
    Addr = a; Rd = 1'b1;
    tick();
    Rd = 1'b0;
  endtask

  task automatic cpu_write_read(input logic [3:0] a, input logic [7:0] d, input logic [7:0] exp);
    exp_q.push_back(exp);
    Addr = a; D_In = d; Wr = 1'b1; Rd = 1'b1;
    tick();
    Wr = 1'b0; Rd = 1'b0;
  endtask

  task automatic stb_pulse(input int p);
    Stb[p] = 1'b1;
    tick();
    Stb[p] = 1'b0;
  endtask

  task automatic wait_ibf(input int p, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (Ibf[p]) break;
      tick();
    end
    check($sformatf("ibf%0d_set", p), 32'(Ibf[p]), 32'd1);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (Rd_Valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rd_valid", 32'(Rd_Valid), 32'd0);
      end else begin
        check("rd_data", 32'(D_Out), 32'(exp_q.pop_front()));
      end
    end else if (!Rst) begin
      check("d_out_idle_zero", 32'(D_Out), 32'd0);
    end
  end

  initial begin
    Rst = 1'b1; Addr = '0; Wr = 1'b0; Rd = 1'b0; D_In = '0; Port_In = '0; Stb = '0;
    repeat (3) tick();
    check("rst_port_out", 32'(Port_Out), 32'd0);
    check("rst_port_oe", 32'(Port_Oe), 32'd0);
    check("rst_ibf", 32'(Ibf), 32'd0);
    check("rst_rd_valid", 32'(Rd_Valid), 32'd0);
    check("rst_d_out", 32'(D_Out), 32'd0);
    Rst = 1'b0;
    tick();

    // simple mode, mixed direction
    cpu_write(4'd4, 8'hF0);
    cpu_write(4'd0, 8'hA5);
    Port_In[7:0] = 8'h3C;
    check("port_oe0", 32'(Port_Oe[7:0]), 32'hF0);
    check("port_out0", 32'(Port_Out[7:0]), 32'hA5);
    repeat (3) tick();
    cpu_read(4'd0, 8'hAC);
    cpu_read(4'd4, 8'hF0);
    cpu_read(4'd8, 8'h00);

    // strobed capture on port 1
    cpu_write(4'd8, 8'h02);
    Port_In[15:8] = 8'h5A;
    stb_pulse(1);
    wait_ibf(1, 3);
    cpu_read(4'd1, 8'h5A);
    check("ibf1_cleared", 32'(Ibf[1]), 32'd0);

    // second strobe while full is dropped and flags overrun
    Port_In[15:8] = 8'h11;
    stb_pulse(1);
    repeat (4) tick();
    Port_In[15:8] = 8'h22;
    stb_pulse(1);
    repeat (4) tick();
    check("ibf1_held", 32'(Ibf[1]), 32'd1);
    cpu_read(4'd1, 8'h11);
    cpu_read(4'd9, 8'h20);
    cpu_read(4'd9, 8'h00);

    // capture and clearing read in the same cycle
    Port_In[15:8] = 8'h33;
    stb_pulse(1);
    wait_ibf(1, 4);
    Port_In[15:8] = 8'h44;
    stb_pulse(1);
    tick();
    cpu_read(4'd1, 8'h33);
    check("ibf1_after_race", 32'(Ibf[1]), 32'd1);
    cpu_read(4'd9, 8'h02);
    cpu_read(4'd1, 8'h44);

    // clearing the MODE bit clears Ibf and OVR
    Port_In[15:8] = 8'h55;
    stb_pulse(1);
    wait_ibf(1, 4);
    Port_In[15:8] = 8'h66;
    stb_pulse(1);
    repeat (4) tick();
    cpu_read(4'd9, 8'h22);
    Port_In[15:8] = 8'h77;
    stb_pulse(1);
    repeat (4) tick();
    cpu_write(4'd8, 8'h00);
    check("ibf1_mode_clear", 32'(Ibf[1]), 32'd0);
    cpu_read(4'd9, 8'h00);
    cpu_read(4'd1, 8'h77);

    // same-cycle write and read returns the pre-write value
    cpu_write(4'd4, 8'hFF);
    cpu_write(4'd0, 8'h00);
    cpu_write_read(4'd0, 8'hFF, 8'h00);
    cpu_read(4'd0, 8'hFF);

    // port 2 partial direction
    cpu_write(4'd6, 8'h0F);
    cpu_write(4'd2, 8'hC3);
    Port_In[23:16] = 8'h96;
    check("port_out2", 32'(Port_Out[23:16]), 32'hC3);
    repeat (3) tick();
    cpu_read(4'd2, 8'h93);

    // unmapped addresses
    cpu_write(4'd3, 8'h77);
    cpu_write(4'd7, 8'h55);
    cpu_write(4'd10, 8'h99);
    cpu_read(4'd3, 8'h00);
    cpu_read(4'd7, 8'h00);
    cpu_read(4'd10, 8'h00);
    cpu_read(4'd15, 8'h00);

    // MODE upper nibble
    cpu_write(4'd8, 8'h11);
`ifdef PPI_IRQ_EN
    cpu_read(4'd8, 8'h11);
    Port_In[7:0] = 8'hE7;
    stb_pulse(0);
    wait_ibf(0, 4);
    tick();
    check("irq_set", 32'(Irq), 32'd1);
    cpu_read(4'd0, 8'hFF);
    tick();
    check("irq_clear", 32'(Irq), 32'd0);
`else
    cpu_read(4'd8, 8'h01);
`endif
    cpu_write(4'd8, 8'h00);

    // reset wins over a concurrent read
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    Addr = 4'd0; Rd = 1'b1; Rst = 1'b1;
    tick();
    Rd = 1'b0;
    tick();
    check("rst_rd_no_valid", 32'(Rd_Valid), 32'd0);
    check("rst2_port_out", 32'(Port_Out), 32'd0);
    check("rst2_port_oe", 32'(Port_Oe), 32'd0);
    Rst = 1'b0;
    repeat (3) tick();
    check("rst2_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ppi_port_bank.md
PPI_PORT_BANK -- requirements
Module: ppi_port_bank

Interface
REQ-001 Parameter DATA_W, default 8: width of each port and of the CPU data bus.
REQ-002 Parameter NUM_PORTS, default 3: number of ports (legal 1..4).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 Rst  input  1  reset, synchronous, active-high.
REQ-005 Addr  input  4  register select.
REQ-006 Wr  input  1  write strobe, one-cycle pulse.
REQ-007 Rd  input  1  read strobe, one-cycle pulse.
REQ-008 D_In  input  DATA_W  CPU write data.
REQ-009 D_Out  output  DATA_W  registered CPU read data.
REQ-010 Rd_Valid  output  1  D_Out valid, one cycle.
REQ-011 Port_In  input  NUM_PORTS*DATA_W  external pin inputs (asynchronous).
REQ-012 Port_Out  output  NUM_PORTS*DATA_W  output latches.
REQ-013 Port_Oe  output  NUM_PORTS*DATA_W  per-bit output enable (1 = drive).
REQ-014 Stb  input  NUM_PORTS  per-port input strobe (asynchronous).
REQ-015 Ibf  output  NUM_PORTS  input-buffer-full flags.

Function
REQ-016 Address map SHALL be: 0..3 data port i; 4..7 DDR i; 8 MODE; 9 STATUS; ports >= NUM_PORTS and 10..15 unmapped.
REQ-017 Write to data port i SHALL load out-latch i; write to DDR i SHALL load DDR i; Port_Out = out-latch, Port_Oe = DDR, visible the cycle after Wr.
REQ-018 MODE bit i SHALL select strobed-input mode for port i (0 = simple).
REQ-019 Port_In and Stb SHALL pass a 2-flop synchronizer before any use.
REQ-020 Read SHALL present data on D_Out with Rd_Valid high exactly one cycle after Rd; D_Out = 0 whenever Rd_Valid is low.
REQ-021 Simple-mode data read SHALL return (DDR & out-latch) | (~DDR & synchronized Port_In).
REQ-022 Strobed-mode: a synchronized Stb rising edge SHALL capture synchronized Port_In into in-latch i and set Ibf[i].
REQ-023 Strobed-mode data read SHALL return (DDR & out-latch) | (~DDR & in-latch) and clear Ibf[i].
REQ-024 Strobe edge while Ibf[i] already set SHALL be dropped (in-latch kept) and SHALL set OVR[i].
REQ-025 Strobe capture and clearing read in the same cycle: read returns old in-latch, Ibf[i] remains set with new data.
REQ-026 STATUS read SHALL return {OVR[3:0], Ibf[3:0]} zero-extended and SHALL clear all OVR bits.
REQ-027 Wr and Rd to the same address in the same cycle: read returns pre-write value; write takes effect.
REQ-028 Unmapped address: writes ignored; reads return 0 with Rd_Valid.
REQ-029 Clearing MODE bit i SHALL clear Ibf[i] and OVR[i].

Reset
REQ-030 Rst SHALL clear out-latches, DDRs (all inputs), MODE, in-latches, Ibf, OVR, synchronizers, D_Out, Rd_Valid, and Irq.
REQ-031 Rst asserted concurrently with Wr, Rd, or Stb SHALL take priority; no read response SHALL follow.

Configuration
REQ-032 Macro PPI_IRQ_EN defined: output Irq (1 bit) SHALL exist, Irq = |(Ibf & IE), registered; IE = MODE bits [7:4].
REQ-033 PPI_IRQ_EN undefined: no Irq port; MODE bits [7:4] SHALL read 0 and ignore writes.

Structure
REQ-034 Package ppi_pkg SHALL hold address constants (ADDR_DATA0, ADDR_DDR0, ADDR_MODE, ADDR_STATUS) and default DATA_W.
REQ-035 Sub-module ppi_sync SHALL implement the 2-flop synchronizer with rising-edge detect; one instance per port for Stb, one per port for Port_In.

Verification
REQ-036 Rst; Wr Addr=4 D_In=8'hF0; Wr Addr=0 D_In=8'hA5; Port_In[0]=8'h3C -> Port_Oe[0]=F0, Port_Out[0]=A5; Rd Addr=0 after 3 cycles -> D_Out=8'hAC, Rd_Valid one cycle.
REQ-037 MODE=8'h02, Port_In[1]=8'h5A, Stb[1] pulse -> Ibf[1]=1 within 3 cycles; Rd Addr=1 -> D_Out=8'h5A, Ibf[1]=0.
REQ-038 Strobed port 1, two Stb pulses with data 11 then 22, no read -> Rd Addr=1 returns 8'h11; Rd Addr=9 returns 8'h20, second STATUS read returns 8'h00.
REQ-039 Wr and Rd Addr=0 same cycle, latch 8'h00, D_In=8'hFF, DDR=FF -> D_Out=8'h00, next read 8'hFF.
REQ-040 Rd Addr=15 -> D_Out=0, Rd_Valid=1; Rst during pending Rd -> Rd_Valid stays 0.
REQ-041 PPI_IRQ_EN: MODE=8'h11, Stb[0] pulse -> Irq=1; Rd Addr=0 -> Irq=0 next cycle.
